// File: rtl/order_decision_engine.sv
// Turns NPU scores into BUY/SELL orders. Orders pass a hysteresis band, a cooldown and
// a net-position limit, then wait in a small show-ahead FIFO for the order-TX path.
module order_decision_engine #(
  parameter int unsigned        COOLDOWN_TICKS = 1250,
  parameter int unsigned        MAX_POSITION   = 4,
  parameter logic signed [31:0] HYST           = 32'sd0,
  parameter int unsigned        FIFO_DEPTH     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic signed [31:0]                threshold,
  input  logic signed [31:0]                result_in,
  input  logic                              result_valid,
  output logic                              m_order_valid,
  input  logic                              m_order_ready,
  output logic                              m_order_side,
  output logic [15:0]                       m_order_seq,
  output logic signed [31:0]                m_order_score,
  output logic signed [7:0]                 position_o,
  output logic [15:0]                       drop_count,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              cooldown_active
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam logic [CW-1:0]     CD_LOAD    = CW'(COOLDOWN_TICKS);
  localparam logic signed [7:0] POS_MAX    = 8'(MAX_POSITION);
  localparam logic signed [7:0] POS_MIN    = 8'sd0 - POS_MAX;
  localparam logic [LW-1:0]     LEVEL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [0:0] {ARMED = 1'b0, COOLING = 1'b1} cd_state_t;

  cd_state_t         state_r;
  logic [CW-1:0]     cd_r;
  logic [15:0]       seq_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic              side_mem_r  [FIFO_DEPTH];
  logic [15:0]       seq_mem_r   [FIFO_DEPTH];
  logic [31:0]       score_mem_r [FIFO_DEPTH];

  logic signed [33:0] score_x_s;
  logic signed [33:0] buy_lim_s;
  logic signed [33:0] sell_lim_s;
  logic               buy_s;
  logic               sell_s;
  logic               accept_s;
  logic               drop_s;
  logic               pop_s;
  logic               full_s;
  logic [LW-1:0]      level_next_s;

  // 34-bit signed operands so threshold +/- HYST can never wrap
  assign score_x_s  = {{2{result_in[31]}}, result_in};
  assign buy_lim_s  = {{2{threshold[31]}}, threshold} - {{2{HYST[31]}}, HYST};
  assign sell_lim_s = {{2{threshold[31]}}, threshold} + {{2{HYST[31]}}, HYST};
  assign full_s     = (fifo_level == LEVEL_FULL);
  assign pop_s      = m_order_valid & m_order_ready;

  assign m_order_side  = side_mem_r[rd_ptr_r];
  assign m_order_seq   = seq_mem_r[rd_ptr_r];
  assign m_order_score = score_mem_r[rd_ptr_r];

  // Band comparison; buy wins if a negative HYST makes both sides true
  always_comb begin
    buy_s  = 1'b0;
    sell_s = 1'b0;
    if (result_valid) begin
      buy_s  = (score_x_s < buy_lim_s);
      sell_s = !buy_s && (score_x_s > sell_lim_s);
    end else begin
      buy_s  = 1'b0;
      sell_s = 1'b0;
    end
  end

  // Gating: full is judged on the registered level, so a same-cycle pop does not help
  always_comb begin
    accept_s = 1'b0;
    drop_s   = 1'b0;
    if (enable && (buy_s || sell_s)) begin
      if ((state_r == ARMED) && !full_s &&
          (buy_s ? (position_o < POS_MAX) : (position_o > POS_MIN))) begin
        accept_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
      drop_s   = 1'b0;
    end
  end

  // Next FIFO occupancy from the push/pop pair
  always_comb begin
    level_next_s = fifo_level;
    case ({accept_s, pop_s})
      2'b10:   level_next_s = fifo_level + LW'(1);
      2'b01:   level_next_s = fifo_level - LW'(1);
      default: level_next_s = fifo_level;
    endcase
  end

  // FIFO storage, pointers, sequence, position and drop telemetry
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      fifo_level    <= '0;
      m_order_valid <= 1'b0;
      seq_r         <= 16'd0;
      position_o    <= 8'sd0;
      drop_count    <= 16'd0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        side_mem_r[i]  <= 1'b0;
        seq_mem_r[i]   <= 16'd0;
        score_mem_r[i] <= 32'd0;
      end
    end else begin
      if (accept_s) begin
        side_mem_r[wr_ptr_r]  <= buy_s;
        seq_mem_r[wr_ptr_r]   <= seq_r;
        score_mem_r[wr_ptr_r] <= result_in;
        wr_ptr_r              <= wr_ptr_r + AW'(1);
        seq_r                 <= seq_r + 16'd1;
        position_o            <= buy_s ? (position_o + 8'sd1) : (position_o - 8'sd1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (drop_s && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
      fifo_level    <= level_next_s;
      m_order_valid <= (level_next_s != '0);
    end
  end

  // Cooldown state machine; a zero load never leaves ARMED
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ARMED;
      cd_r            <= '0;
      cooldown_active <= 1'b0;
    end else begin
      case (state_r)
        ARMED: begin
          if (accept_s && (CD_LOAD != '0)) begin
            state_r         <= COOLING;
            cd_r            <= CD_LOAD;
            cooldown_active <= 1'b1;
          end
        end
        COOLING: begin
          if (cd_r == CW'(1)) begin
            state_r         <= ARMED;
            cd_r            <= '0;
            cooldown_active <= 1'b0;
          end else begin
            cd_r <= cd_r - CW'(1);
          end
        end
        default: begin
          state_r         <= ARMED;
          cd_r            <= '0;
          cooldown_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_order_decision_engine.sv
// Directed scenarios plus a randomized phase, all checked every cycle against a
// queue-based reference model of the order decision rules.
module tb_order_decision_engine;

  localparam int COOL  = 4;
  localparam int MAXP  = 2;
  localparam int HYSTV = 5;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b1;
  logic signed [31:0] threshold = 32'sd100;
  logic signed [31:0] result_in = 32'sd0;
  logic               result_valid = 1'b0;
  logic               m_order_valid;
  logic               m_order_ready = 1'b1;
  logic               m_order_side;
  logic [15:0]        m_order_seq;
  logic signed [31:0] m_order_score;
  logic signed [7:0]  position_o;
  logic [15:0]        drop_count;
  logic [2:0]         fifo_level;
  logic               cooldown_active;

  order_decision_engine #(
    .COOLDOWN_TICKS(COOL),
    .MAX_POSITION  (MAXP),
    .HYST          (32'sd5),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .threshold      (threshold),
    .result_in      (result_in),
    .result_valid   (result_valid),
    .m_order_valid  (m_order_valid),
    .m_order_ready  (m_order_ready),
    .m_order_side   (m_order_side),
    .m_order_seq    (m_order_seq),
    .m_order_score  (m_order_score),
    .position_o     (position_o),
    .drop_count     (drop_count),
    .fifo_level     (fifo_level),
    .cooldown_active(cooldown_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit side;
    int seq;
    int score;
  } order_t;

  order_t q[$];
  int m_pos  = 0;
  int m_drop = 0;
  int m_cd   = 0;
  int m_seq  = 0;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: one clock edge, inputs as sampled at that edge
  task automatic model_edge();
    int     sz;
    longint s, t;
    bit     buy, sell, acc, pop;
    sz = q.size();
    if (rst) begin
      q.delete();
      m_pos = 0; m_drop = 0; m_cd = 0; m_seq = 0;
      return;
    end
    pop  = (sz > 0) && m_order_ready;
    s    = longint'(result_in);
    t    = longint'(threshold);
    buy  = result_valid && (s < t - HYSTV);
    sell = result_valid && !buy && (s > t + HYSTV);
    acc  = 1'b0;
    if (enable && (buy || sell)) begin
      if (m_cd == 0 && sz < DEPTH && (buy ? (m_pos < MAXP) : (m_pos > -MAXP)))
        acc = 1'b1;
      else if (m_drop < 65535)
        m_drop++;
    end
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back('{side: buy, seq: m_seq, score: int'(result_in)});
      m_seq = (m_seq + 1) % 65536;
      m_pos += buy ? 1 : -1;
      m_cd = COOL;
    end else if (m_cd > 0) begin
      m_cd--;
    end
  endtask

  task automatic check_model();
    chk("valid", {31'd0, m_order_valid}, {31'd0, q.size() != 0});
    chk("level", {29'd0, fifo_level}, 32'(q.size()));
    chk("position", {{24{position_o[7]}}, position_o}, 32'(m_pos));
    chk("drops", {16'd0, drop_count}, 32'(m_drop));
    chk("cooldown", {31'd0, cooldown_active}, {31'd0, m_cd != 0});
    if (q.size() > 0) begin
      chk("head_side", {31'd0, m_order_side}, {31'd0, q[0].side});
      chk("head_seq", {16'd0, m_order_seq}, 32'(q[0].seq));
      chk("head_score", m_order_score, q[0].score);
    end
  endtask

  task automatic step(input logic v, input int score);
    result_valid = v;
    result_in    = score;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 0);
    rst = 1'b0;
  endtask

  int seq4[6] = '{50, 200, 50, 200, 50, 50};

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", {31'd0, m_order_valid}, 32'd0);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_side", {31'd0, m_order_side}, 32'd0);
    chk("rst_seq", {16'd0, m_order_seq}, 32'd0);
    chk("rst_score", m_order_score, 32'd0);

    // 1. Band edges and latency
    step(1'b1, 95); step(1'b1, 105); step(1'b1, 100);
    chk("band_none", {29'd0, fifo_level}, 32'd0);
    chk("band_drops", {16'd0, drop_count}, 32'd0);
    step(1'b1, 94);
    chk("s1_valid", {31'd0, m_order_valid}, 32'd1);
    chk("s1_side", {31'd0, m_order_side}, 32'd1);
    chk("s1_seq", {16'd0, m_order_seq}, 32'd0);
    chk("s1_score", m_order_score, 32'd94);
    chk("s1_pos", {{24{position_o[7]}}, position_o}, 32'd1);
    idle(4);
    step(1'b1, 106);
    chk("s1_sell_side", {31'd0, m_order_side}, 32'd0);
    chk("s1_sell_seq", {16'd0, m_order_seq}, 32'd1);
    chk("s1_sell_pos", {{24{position_o[7]}}, position_o}, 32'd0);

    // 2. Cooldown
    do_reset();
    step(1'b1, 50); step(1'b0, 0); step(1'b1, 50); step(1'b0, 0); step(1'b1, 50);
    chk("s2_drops", {16'd0, drop_count}, 32'd2);
    step(1'b1, 50);
    chk("s2_second_buy", {16'd0, m_order_seq}, 32'd1);
    chk("s2_pos", {{24{position_o[7]}}, position_o}, 32'd2);

    // 3. Position limit
    do_reset();
    for (int i = 0; i < 5; i++) begin step(1'b1, 50); idle(4); end
    chk("s3_pos", {{24{position_o[7]}}, position_o}, 32'd2);
    chk("s3_drops", {16'd0, drop_count}, 32'd3);
    step(1'b1, 200);
    chk("s3_sell_pos", {{24{position_o[7]}}, position_o}, 32'd1);

    // 4. Backpressure and full FIFO (alternating sides keeps the position in range)
    do_reset();
    m_order_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin step(1'b1, seq4[i]); idle(4); end
    chk("s4_level", {29'd0, fifo_level}, 32'd4);
    chk("s4_drops", {16'd0, drop_count}, 32'd2);
    idle(3);
    chk("s4_head_hold", {16'd0, m_order_seq}, 32'd0);
    m_order_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("s4_drain_seq", {16'd0, m_order_seq}, 32'(i));
      step(1'b0, 0);
    end
    chk("s4_empty", {29'd0, fifo_level}, 32'd0);

    // 5. Enable low and drop saturation
    enable = 1'b0;
    step(1'b1, 0);
    chk("s5_en_drops", {16'd0, drop_count}, 32'd2);
    chk("s5_en_level", {29'd0, fifo_level}, 32'd0);
    enable = 1'b1;
    do_reset();
    step(1'b1, 50); idle(4); step(1'b1, 50); idle(4);
    for (int i = 0; i < 65536; i++) step(1'b1, 50);
    chk("s5_saturate", {16'd0, drop_count}, 32'h0000FFFF);

    // 6. Reset mid-operation
    do_reset();
    m_order_ready = 1'b0;
    step(1'b1, 50); idle(4); step(1'b1, 200); idle(4); step(1'b1, 50); idle(2);
    chk("s6_level3", {29'd0, fifo_level}, 32'd3);
    chk("s6_cooling", {31'd0, cooldown_active}, 32'd1);
    do_reset();
    chk("s6_valid", {31'd0, m_order_valid}, 32'd0);
    chk("s6_level", {29'd0, fifo_level}, 32'd0);
    chk("s6_pos", {{24{position_o[7]}}, position_o}, 32'd0);
    chk("s6_cd", {31'd0, cooldown_active}, 32'd0);
    step(1'b1, 50);
    chk("s6_buy", {31'd0, m_order_valid}, 32'd1);
    chk("s6_seq", {16'd0, m_order_seq}, 32'd0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      m_order_ready = ($urandom_range(0, 2) != 0);
      enable        = ($urandom_range(0, 9) != 0);
      rst           = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 15) == 0) begin
        threshold = 32'($urandom_range(0, 400)) - 32'sd200;
        step(1'b0, 0);
      end else if ($urandom_range(0, 7) == 0) begin
        step(1'b1, int'($urandom()));
      end else begin
        step($urandom_range(0, 1) == 1, int'(threshold) + int'($urandom_range(0, 40)) - 20);
      end
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
